// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner_if
//  Description : Display-side bundle for seven_seg_scanner: datapath value,
//                decimal points, control strobes and the board display pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    lz_en;
    logic                    blank;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (
        output value, dp, load, lz_en, blank,
        input  seg_n, dp_n, an_n, frame_done
    );

    modport slave (
        input  value, dp, load, lz_en, blank,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Multiplexed N-digit active-low seven-segment driver with
//                guard slots, frame-synchronous loading and zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 1000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scanner_if.slave   bus
);
    localparam int MAX_CYC = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int D_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [D_W-1:0]   C_D_LAST     = D_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [D_W-1:0]          d_q, d_d;
    logic [VAL_W-1:0]        pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [VAL_W-1:0]        shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, frame_done_d;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_supp;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   supp_mask;

    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant nibble are 0.
    always_comb begin
        zero_above = 1'b1;
        supp_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (shadow_val_q[4*i +: 4] == 4'h0);
            supp_mask[i] = (i != 0) && zero_above && !shadow_dp_q[i];
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (d_q == D_W'(i)) begin
                cur_nib  = shadow_val_q[4*i +: 4];
                cur_dp   = shadow_dp_q[i];
                cur_supp = supp_mask[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        d_d          = d_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == C_GUARD_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == C_ON_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    d_d     = (d_q == C_D_LAST) ? '0 : d_q + D_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp;
            pend_valid_d = 1'b1;
        end

        // The edge after the frame_done cycle is the only point the shadow moves.
        if (frame_done_q) begin
            if (bus.load) begin
                shadow_val_d = bus.value;
                shadow_dp_d  = bus.dp;
            end else if (pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end

        frame_done_d = (state_q == ST_DRIVE) && (d_q == C_D_LAST) && (cnt_q == C_ON_LAST);

        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        if (state_q == ST_DRIVE) begin
            seg_n_d = font(cur_nib);
            dp_n_d  = ~cur_dp;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n_d[i] = !((state_q == ST_DRIVE) && (d_q == D_W'(i)) &&
                          !bus.blank && !(bus.lz_en && cur_supp));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GUARD;
            cnt_q        <= '0;
            d_q          <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            d_q          <= d_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Directed self-checking bench for seven_seg_scanner
//                (4 digits, ON=4, GUARD=1: slot 5 cycles, frame 20 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;

    seven_seg_scanner_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS   (4),
        .ON_CYCLES    (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc = index of the rising edge whose results are visible at this negedge
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        bus.value = v;
        bus.dp    = p;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    task automatic check_slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                              input logic dpn);
        check({tag, ".an"},  {28'd0, bus.an_n},  {28'd0, an});
        check({tag, ".seg"}, {25'd0, bus.seg_n}, {25'd0, seg});
        check({tag, ".dp"},  {31'd0, bus.dp_n},  {31'd0, dpn});
    endtask

    initial begin
        logic [3:0] exp_an;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.value = '0;
        bus.dp    = '0;
        bus.load  = 1'b0;
        bus.lz_en = 1'b0;
        bus.blank = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.seg", {25'd0, bus.seg_n}, 32'h7F);
        check("rst.an",  {28'd0, bus.an_n},  32'hF);
        check("rst.dp",  {31'd0, bus.dp_n},  32'h1);
        check("rst.fd",  {31'd0, bus.frame_done}, 32'h0);

        // Release: the next rising edge is cycle 0.
        rst = 1'b0;
        cyc = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            exp_an = ((c % 5) == 0) ? 4'hF : ~(4'b0001 << ((c % 20) / 5));
            check($sformatf("scan.an@%0d", c), {28'd0, bus.an_n}, {28'd0, exp_an});
            check($sformatf("scan.fd@%0d", c), {31'd0, bus.frame_done},
                  ((c % 20) == 19) ? 32'h1 : 32'h0);
            check($sformatf("scan.seg@%0d", c), {25'd0, bus.seg_n},
                  ((c % 5) == 0) ? 32'h7F : 32'h40);
        end

        // Mid-frame load stays hidden until the boundary at edge 60.
        goto(45);
        do_load(16'h12AB, 4'b0100);
        goto(51);
        check_slot("hold.d2", 4'hB, 7'h40, 1'b1);
        goto(56);
        check_slot("hold.d3", 4'h7, 7'h40, 1'b1);
        goto(61);
        check_slot("new.d0", 4'hE, 7'h03, 1'b1);
        goto(66);
        check_slot("new.d1", 4'hD, 7'h08, 1'b1);
        goto(70);
        check_slot("new.g2", 4'hF, 7'h7F, 1'b1);
        goto(71);
        check_slot("new.d2", 4'hB, 7'h24, 1'b0);
        goto(76);
        check_slot("new.d3", 4'h7, 7'h79, 1'b1);

        // Leading zeros: 0070 shown from frame 100.
        goto(80);
        bus.lz_en = 1'b1;
        do_load(16'h0070, 4'b0000);
        goto(101);
        check_slot("lz.d0", 4'hE, 7'h40, 1'b1);
        goto(106);
        check_slot("lz.d1", 4'hD, 7'h78, 1'b1);
        goto(111);
        check("lz.d2.an", {28'd0, bus.an_n}, 32'hF);
        goto(116);
        check("lz.d3.an", {28'd0, bus.an_n}, 32'hF);
        bus.lz_en = 1'b0;
        goto(121);
        check("nolz.d0.an", {28'd0, bus.an_n}, 32'hE);
        goto(125);
        do_load(16'h0000, 4'b0000);
        goto(131);
        check_slot("nolz.d2", 4'hB, 7'h40, 1'b1);
        goto(136);
        check_slot("nolz.d3", 4'h7, 7'h40, 1'b1);
        bus.lz_en = 1'b1;
        goto(141);
        check_slot("zero.d0", 4'hE, 7'h40, 1'b1);
        goto(146);
        check("zero.d1.an", {28'd0, bus.an_n}, 32'hF);
        goto(151);
        check("zero.d2.an", {28'd0, bus.an_n}, 32'hF);
        goto(156);
        check("zero.d3.an", {28'd0, bus.an_n}, 32'hF);

        // Load coinciding with frame_done takes effect on the very next edge.
        goto(159);
        check("fdload.fd", {31'd0, bus.frame_done}, 32'h1);
        bus.lz_en = 1'b0;
        do_load(16'hFFFF, 4'b0000);
        goto(161);
        check_slot("fdload.d0", 4'hE, 7'h0E, 1'b1);
        goto(165);
        do_load(16'h1111, 4'b0000);
        goto(171);
        check_slot("second.hold.d2", 4'hB, 7'h0E, 1'b1);
        goto(176);
        check_slot("second.hold.d3", 4'h7, 7'h0E, 1'b1);
        goto(181);
        check_slot("second.d0", 4'hE, 7'h79, 1'b1);

        // Blank one whole frame: anodes off, frame_done keeps its period.
        goto(199);
        bus.blank = 1'b1;
        for (int c = 200; c < 220; c++) begin
            step();
            check($sformatf("blank.an@%0d", c), {28'd0, bus.an_n}, 32'hF);
            check($sformatf("blank.fd@%0d", c), {31'd0, bus.frame_done},
                  (c == 219) ? 32'h1 : 32'h0);
        end
        bus.blank = 1'b0;
        goto(221);
        check_slot("unblank.d0", 4'hE, 7'h79, 1'b1);
        goto(226);
        check_slot("unblank.d1", 4'hD, 7'h79, 1'b1);

        // Reset during digit 2 drive clears the display contents.
        goto(232);
        check("prerst.an", {28'd0, bus.an_n}, 32'hB);
        rst = 1'b1;
        step();
        check_slot("midrst", 4'hF, 7'h7F, 1'b1);
        check("midrst.fd", {31'd0, bus.frame_done}, 32'h0);
        rst = 1'b0;
        cyc = -1;
        goto(0);
        check("postrst.c0.an", {28'd0, bus.an_n}, 32'hF);
        goto(1);
        check_slot("postrst.d0", 4'hE, 7'h40, 1'b1);
        goto(6);
        check_slot("postrst.d1", 4'hD, 7'h40, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit hex decoder. It latches an N-nibble value and scans the digits one at a time through shared segment lines. Between digits it inserts a guard interval to prevent ghosting, and it can optionally suppress leading zeros. It sits between the datapath registers and the board display pins and uses the existing active-low hex font: 0–9, A, b, C, d, E, F.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- ON_CYCLES, 1000, clock cycles each digit's anode is driven (≥1)
- GUARD_CYCLES, 16, clock cycles with all anodes off before each digit (≥1)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 least significant
- dp  in  NUM_DIGITS  decimal point request per digit, active-high
- load  in  1  one-cycle strobe; samples value and dp
- lz_en  in  1  leading-zero suppression enable
- blank  in  1  forces all anodes off while high; scanning continues
- seg_n  out  7  segments, active-low; bit0=A … bit6=G
- dp_n  out  1  decimal point, active-low
- an_n  out  NUM_DIGITS  digit anodes, active-low, one-hot-or-none
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- Registers:
  - pending (value+dp) and pending_valid.
  - shadow (value+dp): the displayed copy.
  - digit index d.
  - slot counter cnt.
  - state ∈ {GUARD, DRIVE}.
- Reset values:
  - seg_n=7'h7F, dp_n=1, an_n=all 1, frame_done=0.
  - shadow=0, pending=0, pending_valid=0.
  - d=0, cnt=0, state=GUARD.
- GUARD: an_n all 1, seg_n=7'h7F, dp_n=1. cnt counts 0..GUARD_CYCLES-1, then state→DRIVE and cnt→0.
- DRIVE: an_n[d]=0 (unless suppressed or blank); seg_n=font(shadow nibble d); dp_n=~shadow_dp[d]. cnt counts 0..ON_CYCLES-1, then state→GUARD, cnt→0, d→d+1.
- Wrap: d=NUM_DIGITS-1 → 0.
- frame_done=1 for exactly the last DRIVE cycle of digit NUM_DIGITS-1.
- Load: when load=1, pending←{value,dp} and pending_valid←1. Loads may repeat; the last one before the frame boundary wins.
- Frame boundary (the edge ending the frame_done cycle):
  - if load=1 in that cycle, shadow←{value,dp} directly;
  - else if pending_valid, shadow←pending.
  - pending_valid←0 in both cases.
  - Mid-frame loads never change the displayed digits (no tearing).
- Leading-zero suppression (lz_en=1): digit i≥1 is suppressed when shadow nibbles i..NUM_DIGITS-1 are all 0. A suppressed digit keeps an_n all 1 but still occupies its time slot. Digit 0 is never suppressed. A digit with dp set is never suppressed.
- blank=1: an_n forced all 1 on the next edge. Counters, d, load and frame_done behave normally.
- The font encoding (seg_n as {G..A}) is fixed:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- rst=1 mid-scan: all state returns to reset values on that edge; the displayed value is lost.

## Timing
- All outputs are registered. The first edge with rst=0 is cycle 0.
- Slot length S = GUARD_CYCLES+ON_CYCLES. Frame length = NUM_DIGITS·S.
- an_n[0] goes low on edge GUARD_CYCLES and stays low for ON_CYCLES cycles. Digit k's anode starts at edge k·S+GUARD_CYCLES.
- seg_n, dp_n and an_n change on the same edge. No output glitch between digits: every anode transition passes through GUARD.
- Load-to-display latency: at most one frame plus one cycle; exactly 1 cycle when load coincides with frame_done.

## Test plan
All scenarios use NUM_DIGITS=4, ON_CYCLES=4, GUARD_CYCLES=1 (S=5, frame=20).

- Reset: hold rst 3 cycles → seg_n=7F, an_n=F, dp_n=1, frame_done=0. Release → an_n=E during cycles 1–4, D during 6–9, B during 11–14, 7 during 16–19; F in cycles 0, 5, 10, 15; frame_done=1 only at cycle 19, then every 20 cycles.
- Load 16'h12AB with dp=4'b0100 mid-frame → digits unchanged until frame boundary. Next frame shows seg_n 03, 08, 24, 79 for digits 0..3; dp_n=0 only during digit 2.
- Leading zeros: load 16'h0070 with lz_en=1 → digit0 seg 40; digit1 seg 78; digits 2,3 an_n stays F. With lz_en=0 all four anodes assert. Load 16'h0000 → only digit 0 lit (40).
- Load asserted in the frame_done cycle with 16'hFFFF → the very next DRIVE of digit 0 shows 0E; a second load mid-frame with 16'h1111 appears only after the next boundary.
- blank=1 for one full frame → an_n=F throughout, frame_done still pulses at period 20. Deassert → anodes resume in slot order.
- rst asserted during digit 2 DRIVE → next cycle an_n=F, seg_n=7F; shadow=0, so after release digit 0 shows 40.
